serial_feeder: RTL and testbench

Parallel-to-serial source stage that sits directly upstream of the `mealy`/`moore` sequence detectors. It accepts a parallel word through a valid/ready handshake and drives it onto the detectors' 1-bit `in` input, LSB first, one bit per clock. It replaces hand-timed bench shifting with a synthesizable, stallable, gapless bit stream.

---
 rtl/serial_pkg.sv | 13 +
 rtl/serial_feeder.sv | 80 ++++++++
 tb/tb_serial_feeder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding, default width and length clamp for serial_feeder
package serial_pkg;

    localparam int SERIAL_WIDTH = 24;

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

    // zero or oversize requests mean "send the full word"
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return (len == 0 || len > width) ? width : len;
    endfunction

endpackage

// File: rtl/serial_feeder.sv
// serial_feeder: LSB-first parallel-to-serial source with valid/ready load, stall and gapless reload
// Optional trailing even-parity bit when SERIAL_FEEDER_PARITY_EN is defined.
module serial_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH,
    localparam int LW = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LW-1:0]    load_len,
    input  logic             stall,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [LW-1:0]    count;
    logic [LW-1:0]    len_eff;
    logic             last_bit;
    logic             accept;

`ifdef SERIAL_FEEDER_PARITY_EN
    logic parity;
    assign last_bit = state == PAR;
    assign out      = (state == SHIFT) ? shift_reg[0] : (state == PAR) && parity;
`else
    assign last_bit = (state == SHIFT) && (count == LW'(1));
    assign out      = (state == SHIFT) && shift_reg[0];
`endif

    assign len_eff    = LW'(clamp_len(32'(load_len), WIDTH));
    assign load_ready = (state == IDLE) || (last_bit && !stall);
    assign accept     = load_valid && load_ready;
    assign out_valid  = state != IDLE;
    assign busy       = state != IDLE;

    // advance one bit per unstalled edge; a reload on the final bit overrides the retire
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
            done      <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            done <= !stall && last_bit;
            if (!stall && state == SHIFT) begin
                shift_reg <= shift_reg >> 1;
                count     <= count - LW'(count != '0);
`ifdef SERIAL_FEEDER_PARITY_EN
                parity    <= parity ^ shift_reg[0];
                if (count == LW'(1)) state <= PAR;
`else
                if (count == LW'(1)) state <= IDLE;
`endif
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            if (!stall && state == PAR) state <= IDLE;
`endif
            if (accept) begin
                state     <= SHIFT;
                shift_reg <= load_data;
                count     <= len_eff;
`ifdef SERIAL_FEEDER_PARITY_EN
                parity    <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// tb_serial_feeder: directed and random stimulus checked against a bit-queue model of the serial stream
module tb_serial_feeder;

    localparam int W  = 24;
    localparam int LW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          rst = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [W-1:0]  load_data = '0;
    logic [LW-1:0] load_len = '0;
    logic          stall = 1'b0;
    logic          out, out_valid, busy, done;

    int n_chk = 0;
    int n_fail = 0;

    bit   q[$];
    logic exp_done = 1'b0;
    logic last_acc = 1'b0;

    serial_feeder dut (
        .clock(clock), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len), .stall(stall),
        .out(out), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("out", 32'(out), 32'(q.size() > 0 ? q[0] : 1'b0));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("done", 32'(done), 32'(exp_done));
        chk("load_ready", 32'(load_ready), 32'(q.size() == 0 || (q.size() == 1 && !stall)));
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic [LW-1:0] l);
        int n;
        logic p;
        n = (l == 0 || int'(l) > W) ? W : int'(l);
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            p ^= d[i];
        end
`ifdef SERIAL_FEEDER_PARITY_EN
        q.push_back(p);
`endif
    endtask

    // one clock: drive at negedge, check, then predict the effect of the next posedge
    task automatic step(input logic v, input logic [W-1:0] d, input logic [LW-1:0] l, input logic s);
        logic nd;
        @(negedge clock);
        load_valid = v;
        load_data  = d;
        load_len   = l;
        stall      = s;
        #1;
        check_outputs();
        last_acc = v && (q.size() == 0 || (q.size() == 1 && !s));
        nd = 1'b0;
        if (!s && q.size() > 0) begin
            void'(q.pop_front());
            nd = q.size() == 0;
        end
        if (last_acc) push_word(d, l);
        exp_done = nd;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, d, l, 1'b0);
            if (last_acc) break;
        end
        chk("accept", 32'(last_acc), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        #11 rst = 1'b1;

        send(24'hCD4D54, 5'd0);
        idle(30);

        send(24'h0000B3, 5'd8);
        idle(12);

        send(24'h0000B3, 5'd8);
        send(24'h000005, 5'd3);
        idle(8);

        send(24'h0000B3, 5'd8);
        idle(4);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
        idle(10);

        send(24'hCD4D54, 5'd24);
        idle(5);
        @(negedge clock);
        #2 rst = 1'b0;
        #1;
        q.delete();
        exp_done = 1'b0;
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_load_ready", 32'(load_ready), 32'd1);
        @(negedge clock);
        rst = 1'b1;
        idle(2);

        send(24'h123456, 5'd31);
        idle(30);

        for (int i = 0; i < 600; i++)
            step(($urandom % 3) != 0, W'($urandom), LW'($urandom % 32), ($urandom % 4) == 0);
        idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
